// File: rtl/mul_issue_ctrl.sv
// Issue controller for the start/finish multiplier. It takes one operand pair at a time,
// pulses start, waits for finish with a timeout, and hands the product to a valid/ready sink.
module mul_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_res,
  input  logic                 mul_finish,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_res,
  output logic                 out_timeout,
  output logic [15:0]          op_count
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t          state;
  logic [TW-1:0]   timer;

  // Handshake and start outputs come from the state register only, never from inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign mul_start = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_res     <= '0;
      out_timeout <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_a <= in_a;
            mul_b <= in_b;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        // A finish in the last timer cycle still counts as a normal result.
        WAIT: begin
          if (mul_finish) begin
            out_res     <= mul_res;
            out_timeout <= 1'b0;
            state       <= OUT;
          end else if (timer == TIMER_LAST) begin
            out_res     <= '0;
            out_timeout <= 1'b1;
            state       <= OUT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (!out_timeout) op_count <= op_count + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Table-driven bench for mul_issue_ctrl with a small start/finish multiplier model
// whose finish delay is set per vector (0 = never finishes).
module tb_mul_issue_ctrl;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          mul_start;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic [63:0]   mul_res;
  logic          mul_finish;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_res;
  logic          out_timeout;
  logic [15:0]   op_count;

  int            checks = 0;
  int            errors = 0;
  int            exp_count = 0;
  int            fin_delay = 0;
  int            wcnt = 0;
  logic          force_fin = 1'b0;

  mul_issue_ctrl #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_res(mul_res), .mul_finish(mul_finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_timeout(out_timeout), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: wcnt is 1 in the first WAIT cycle after start is sampled.
  always @(posedge clk) begin
    if (mul_start) wcnt <= 1;
    else if (wcnt != 0) wcnt <= wcnt + 1;
  end
  assign mul_finish = ((wcnt != 0) && (wcnt == fin_delay)) || force_fin;
  assign mul_res    = 64'(mul_a) * 64'(mul_b);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    int          stall;
    logic [63:0] res;
    logic        to;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int   cyc;
    int   starts;
    bit   stable;
    out_ready = (v.stall == 0);
    fin_delay = v.delay;
    checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a = v.a;
    in_b = v.b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = ~v.a;
    in_b = ~v.b;
    checkOutput("mul_start_issue", 64'(mul_start), 64'd1);
    checkOutput("mul_a_latched", 64'(mul_a), 64'(v.a));
    checkOutput("mul_b_latched", 64'(mul_b), 64'(v.b));
    cyc = 1;
    starts = 0;
    stable = 1'b1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mul_start) starts++;
      if (mul_a !== v.a || mul_b !== v.b) stable = 1'b0;
    end
    checkOutput("out_valid_seen", 64'(out_valid), 64'd1);
    checkOutput("latency", 64'(cyc), 64'(v.lat));
    checkOutput("mul_start_single", 64'(starts), 64'd0);
    checkOutput("operands_stable", 64'(stable), 64'd1);
    checkOutput("out_res", out_res, v.res);
    checkOutput("out_timeout", 64'(out_timeout), 64'(v.to));
    if (v.stall > 0) begin
      in_valid = 1'b1;
      in_a = 32'hDEAD_BEEF;
      in_b = 32'h0000_0002;
      for (int i = 0; i < v.stall; i++) begin
        @(negedge clk);
        checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_out_res", out_res, v.res);
        checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    if (!v.to) exp_count++;
    checkOutput("back_to_idle", 64'(in_ready), 64'd1);
    checkOutput("out_valid_drop", 64'(out_valid), 64'd0);
    checkOutput("op_count", 64'(op_count), 64'(exp_count));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{32'd3,         32'd5,         1, 0, 64'd15,                  1'b0, 3};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0, 64'hFFFF_FFFE_0000_0001, 1'b0, 5};
    vecs[2] = '{32'h1234,      32'h10,        1, 5, 64'h12340,               1'b0, 3};
    vecs[3] = '{32'd7,         32'd9,         0, 0, 64'd0,                   1'b1, 10};
    vecs[4] = '{32'd6,         32'd7,         8, 0, 64'd42,                  1'b0, 10};
    vecs[5] = '{32'h1_0000,    32'h1_0000,    2, 0, 64'h1_0000_0000,         1'b0, 4};
    vecs[6] = '{32'd5,         32'd0,         0, 2, 64'd0,                   1'b1, 10};
    vecs[7] = '{32'd11,        32'd13,        9, 0, 64'd0,                   1'b1, 10};

    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 32'd3;
    in_b = 32'd4;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mul_start", 64'(mul_start), 64'd0);
    checkOutput("rst_op_count", 64'(op_count), 64'd0);
    checkOutput("rst_out_timeout", 64'(out_timeout), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_no_accept", 64'(in_ready), 64'd1);
    checkOutput("rst_no_start", 64'(mul_start), 64'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    fin_delay = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 32'd2;
    in_b = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_wait_no_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_mul_a", 64'(mul_a), 64'd0);
    checkOutput("mid_rst_mul_b", 64'(mul_b), 64'd0);
    checkOutput("mid_rst_out_res", out_res, 64'd0);
    checkOutput("mid_rst_op_count", 64'(op_count), 64'd0);
    checkOutput("mid_rst_mul_start", 64'(mul_start), 64'd0);
    force_fin = 1'b1;
    @(negedge clk);
    force_fin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("late_finish_out_valid", 64'(out_valid), 64'd0);
      checkOutput("late_finish_in_ready", 64'(in_ready), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Control stage directly upstream of the lab's start/finish multiplier. It accepts one operand pair at a time from a valid/ready source and holds the operands stable on the multiplier inputs. It issues a single-cycle start pulse, waits for finish under a timeout, and returns the 2*WIDTH product to a valid/ready sink. One transaction is in flight at a time; the block also counts successful products.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH.
TIMEOUT, 64, maximum WAIT cycles for mul_finish before giving up; must be >= 2.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operand pair valid.
in_ready  output  1  controller can accept an operand pair.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
mul_start  output  1  start pulse to the multiplier.
mul_a  output  WIDTH  latched operand A to the multiplier.
mul_b  output  WIDTH  latched operand B to the multiplier.
mul_res  input  2*WIDTH  product from the multiplier.
mul_finish  input  1  multiplier completion flag.
out_valid  output  1  result valid.
out_ready  input  1  sink accepts the result.
out_res  output  2*WIDTH  captured product; 0 on timeout.
out_timeout  output  1  qualifies out_res; 1 means no finish arrived in time.
op_count  output  16  count of successful products delivered; wraps from 0xFFFF to 0.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; mul_start, mul_a, mul_b, out_valid, out_res, out_timeout, op_count and the timer all go to 0. Inputs in that cycle are ignored. Reset is honoured in every state; an in-flight transaction is dropped.
- All outputs are registered or decoded from state only. There is no combinational path from input to output.
- in_ready=1 only in IDLE. out_valid=1 only in OUT. mul_start=1 only in ISSUE.
- IDLE: if in_valid & in_ready, latch in_a->mul_a and in_b->mul_b, then go to ISSUE.
- ISSUE (exactly one cycle): mul_start=1 and timer<=0. Go to WAIT.
- WAIT: mul_start=0; mul_a/mul_b stay stable.
  - If mul_finish=1: out_res<=mul_res, out_timeout<=0, go to OUT.
  - Else, if timer==TIMEOUT-1: out_res<=0, out_timeout<=1, go to OUT.
  - Else: timer<=timer+1.
  - If finish and timeout coincide, finish wins.
- OUT: out_res and out_timeout are held stable while out_ready=0. When out_ready=1, go to IDLE; op_count increments in that cycle only if out_timeout=0.
- mul_finish in IDLE, ISSUE or OUT is ignored, so a late finish after a timeout has no effect.
- Latency, with a multiplier that raises finish the cycle after it samples start:
  - cycle 0: input handshake.
  - cycle 1: mul_start=1.
  - cycle 2: finish seen and product captured.
  - cycle 3: out_valid=1.
  - If out_ready is high in cycle 3, in_ready returns to 1 in cycle 4.
  - Minimum initiation interval: 4 cycles.
- Width: out_res is the full 2*WIDTH, with no truncation or sign handling (unsigned pass-through).
- Timer width: $clog2(TIMEOUT)+1 bits.

Test Plan:
1. Reset: hold rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, mul_start=0, op_count=0, out_timeout=0, and no transaction accepted.
2. Basic: in_a=3, in_b=5; model returns mul_res=15 one cycle after start -> mul_start high exactly 1 cycle, out_valid 3 cycles after accept, out_res=15, out_timeout=0, op_count=1.
3. Max operands: in_a=in_b=0xFFFFFFFF; model res=0xFFFFFFFE00000001 -> out_res=0xFFFFFFFE00000001, and mul_a/mul_b stay stable throughout WAIT.
4. Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_valid and out_res stable, in_ready=0, no new accept; after out_ready=1, the next pair is accepted the following cycle.
5. Timeout, TIMEOUT=8:
   - Model never finishes -> out_valid after 8 WAIT cycles, out_timeout=1, out_res=0, op_count unchanged.
   - Repeat with finish exactly on WAIT cycle 8 -> normal result, out_timeout=0.
6. Reset mid-operation: rst asserted in WAIT -> next cycle IDLE with all outputs 0; a mul_finish arriving afterwards is ignored and out_valid stays 0.
